// File: rtl/qsys_pio_in_scanner.sv
// Avalon-MM scanner for a 16-bit PIO input: periodic polling, debounce,
// sticky rise/fall edge flags and a maskable level interrupt.
module qsys_pio_in_scanner #(
  parameter int WIDTH   = 16,
  parameter int DIV_W   = 16,
  parameter int DEB_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2
  } scan_state_t;

  scan_state_t       fsm_r, fsm_s;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  period_r;
  logic              enable_r;
  logic              tick_s;
  logic              m_read_r;
  logic [WIDTH-1:0]  cand_r, cand_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [WIDTH-1:0]  state_r;
  logic [WIDTH-1:0]  rise_r, fall_r;
  logic [WIDTH-1:0]  imask_rise_r, imask_fall_r;
  logic [WIDTH-1:0]  rise_set_s, fall_set_s;
  logic [WIDTH-1:0]  rise_clr_s, fall_clr_s;
  logic              accept_s;
  logic              wr_edge_s, wr_imask_s, wr_ctrl_s;
  logic [31:0]       rd_mux_s;
  logic [31:0]       s_readdata_r;
  logic              unused_hi_s;

  // Place a rise/fall style pair into the 32-bit register layout.
  function automatic logic [31:0] pack_pair(input logic [WIDTH-1:0] lo,
                                            input logic [WIDTH-1:0] hi);
    logic [31:0] r;
    r = 32'd0;
    r[WIDTH-1:0]     = lo;
    r[WIDTH+15:16]   = hi;
    return r;
  endfunction

  assign unused_hi_s = ^{m_readdata[31:WIDTH], 1'b0};
  assign m_address   = 2'd0;
  assign m_read      = m_read_r;
  assign s_readdata  = s_readdata_r;
  // Combinational from the flag registers so it follows them within the same clk.
  assign irq         = |((rise_r & imask_rise_r) | (fall_r & imask_fall_r));

  assign wr_edge_s  = s_write && (s_address == 2'd1);
  assign wr_imask_s = s_write && (s_address == 2'd2);
  assign wr_ctrl_s  = s_write && (s_address == 2'd3);
  // ">=" rather than "==" so a period shrunk below the running count still wraps.
  assign tick_s     = enable_r && (div_r >= period_r);

  // Scan-period divider; held at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= {DIV_W{1'b0}};
    end else if (!enable_r || tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Scan sequencer next state; ticks arriving outside IDLE are dropped.
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (tick_s) fsm_s = ST_REQ;
        else        fsm_s = ST_IDLE;
      end
      ST_REQ:  fsm_s = ST_CAPT;
      ST_CAPT: fsm_s = ST_IDLE;
      default: fsm_s = ST_IDLE;
    endcase
  end

  // Sequencer state and the registered PIO read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_r    <= ST_IDLE;
      m_read_r <= 1'b0;
    end else begin
      fsm_r    <= fsm_s;
      m_read_r <= (fsm_s == ST_REQ);
    end
  end

  // Debounce update for the sample captured in CAPT.
  always_comb begin
    cand_s     = cand_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    rise_set_s = {WIDTH{1'b0}};
    fall_set_s = {WIDTH{1'b0}};
    if (fsm_r == ST_CAPT) begin
      if (m_readdata[WIDTH-1:0] != cand_r) begin
        cand_s = m_readdata[WIDTH-1:0];
        cnt_s  = CNT_W'(1);
      end else if (cnt_r < CNT_W'(DEB_CNT)) begin
        cnt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_s = cnt_r;
      end
      accept_s = (cnt_s == CNT_W'(DEB_CNT)) && (cand_s != state_r);
      if (accept_s) begin
        rise_set_s = cand_s & ~state_r;
        fall_set_s = ~cand_s & state_r;
      end else begin
        rise_set_s = {WIDTH{1'b0}};
        fall_set_s = {WIDTH{1'b0}};
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // W1C masks from a CPU write to EDGE.
  always_comb begin
    rise_clr_s = {WIDTH{1'b0}};
    fall_clr_s = {WIDTH{1'b0}};
    if (wr_edge_s) begin
      rise_clr_s = s_writedata[WIDTH-1:0];
      fall_clr_s = s_writedata[WIDTH+15:16];
    end else begin
      rise_clr_s = {WIDTH{1'b0}};
      fall_clr_s = {WIDTH{1'b0}};
    end
  end

  // Debounce state, accepted value and sticky edges; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= {WIDTH{1'b0}};
      rise_r  <= {WIDTH{1'b0}};
      fall_r  <= {WIDTH{1'b0}};
    end else begin
      cand_r  <= cand_s;
      cnt_r   <= cnt_s;
      state_r <= accept_s ? cand_s : state_r;
      rise_r  <= (rise_r & ~rise_clr_s) | rise_set_s;
      fall_r  <= (fall_r & ~fall_clr_s) | fall_set_s;
    end
  end

  // CPU-writable IMASK and CTRL registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imask_rise_r <= {WIDTH{1'b0}};
      imask_fall_r <= {WIDTH{1'b0}};
      enable_r     <= 1'b0;
      period_r     <= {DIV_W{1'b0}};
    end else begin
      if (wr_imask_s) begin
        imask_rise_r <= s_writedata[WIDTH-1:0];
        imask_fall_r <= s_writedata[WIDTH+15:16];
      end
      if (wr_ctrl_s) begin
        enable_r <= s_writedata[0];
        period_r <= s_writedata[DIV_W+15:16];
      end
    end
  end

  // CPU read mux; unused bits read as zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (s_address)
      2'd0: rd_mux_s = pack_pair(state_r, {WIDTH{1'b0}});
      2'd1: rd_mux_s = pack_pair(rise_r, fall_r);
      2'd2: rd_mux_s = pack_pair(imask_rise_r, imask_fall_r);
      2'd3: begin
        rd_mux_s                = 32'd0;
        rd_mux_s[0]             = enable_r;
        rd_mux_s[DIV_W+15:16]   = period_r;
      end
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data, zero whenever no read is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata_r <= 32'd0;
    end else if (s_read) begin
      s_readdata_r <= rd_mux_s;
    end else begin
      s_readdata_r <= 32'd0;
    end
  end

endmodule

// File: tb/tb_qsys_pio_in_scanner.sv
// Randomized bench for qsys_pio_in_scanner: a PIO responder plus a
// window-based debounce/register model checked every clock.
module tb_qsys_pio_in_scanner;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic [1:0]  s_address = 2'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic        irq;
  logic [15:0] in_port = 16'd0;
  logic [31:0] pio_rd = 32'd0;

  int checks = 0;
  int errors = 0;

  // model
  logic [15:0] state_m;
  logic [31:0] edge_m, imask_m;
  logic        en_m;
  logic [15:0] period_m;
  logic [15:0] hist[$];
  logic        saw_mread, pend_valid;
  logic [15:0] pend_sample;
  int          cyc = 0;
  int          last_pulse = 0;
  logic        last_valid = 1'b0;
  logic        no_scan_chk = 1'b0;
  logic        int_chk = 1'b0;
  int          exp_int = 0;
  int          pulses = 0;

  qsys_pio_in_scanner dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // PIO slave with one-cycle registered read latency and junk upper bits.
  always @(posedge clk) begin
    if (m_read) pio_rd <= {16'($urandom), in_port};
  end
  assign m_readdata = pio_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    state_m = 16'd0; edge_m = 32'd0; imask_m = 32'd0; en_m = 1'b0; period_m = 16'd0;
    hist.delete();
    saw_mread = 1'b0; pend_valid = 1'b0; pend_sample = 16'd0; last_valid = 1'b0;
  endtask

  function automatic logic [31:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0: return {16'd0, state_m};
      2'd1: return edge_m;
      2'd2: return imask_m;
      default: return {period_m, 15'd0, en_m};
    endcase
  endfunction

  // Accept a value once the last DEB samples agree and differ from STATE.
  task automatic model_commit(input logic [15:0] s);
    logic all_eq;
    hist.push_back(s);
    if (hist.size() > DEB) hist.delete(0);
    all_eq = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != s) all_eq = 1'b0;
    if (all_eq && s != state_m) begin
      edge_m[15:0]  = edge_m[15:0]  | (s & ~state_m);
      edge_m[31:16] = edge_m[31:16] | (~s & state_m);
      state_m = s;
    end
  endtask

  task automatic step();
    logic        w, r, do_commit;
    logic [1:0]  a;
    logic [31:0] wd, rd_exp;
    logic [15:0] cval;
    w = s_write; r = s_read; a = s_address; wd = s_writedata;
    rd_exp = r ? reg_view(a) : 32'd0;
    do_commit = pend_valid; cval = pend_sample; pend_valid = 1'b0;
    @(posedge clk); #1; cyc++;
    if (w) begin
      case (a)
        2'd1: edge_m = edge_m & ~wd;
        2'd2: imask_m = wd;
        2'd3: begin en_m = wd[0]; period_m = wd[31:16]; last_valid = 1'b0; end
        default: ;
      endcase
    end
    if (do_commit) model_commit(cval);
    if (saw_mread) begin pend_valid = 1'b1; pend_sample = pio_rd[15:0]; end
    check_val("s_readdata", s_readdata, rd_exp);
    check_val("irq", {31'd0, irq}, {31'd0, |(edge_m & imask_m)});
    check_val("m_address", {30'd0, m_address}, 32'd0);
    if (no_scan_chk) check_val("m_read_disabled", {31'd0, m_read}, 32'd0);
    if (m_read) begin
      check_val("m_read_width", {31'd0, saw_mread}, 32'd0);
      if (int_chk && last_valid) check_val("scan_interval", cyc - last_pulse, exp_int);
      last_pulse = cyc; last_valid = 1'b1; pulses++;
    end
    saw_mread = m_read;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    s_write = 1'b1; s_address = a; s_writedata = d;
    step();
    s_write = 1'b0; s_address = 2'd0; s_writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    s_read = 1'b1; s_address = a;
    step();
    d = s_readdata;
    s_read = 1'b0; s_address = 2'd0;
  endtask

  task automatic wait_mread(input int bound);
    int n = 0;
    do begin step(); n++; end while (!m_read && n < bound);
    check_val("wait_mread", {31'd0, m_read}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [15:0] pats[4];

  initial begin
    pats[0] = 16'h0000; pats[1] = 16'h00A5; pats[2] = 16'h5A5A; pats[3] = 16'hFFFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_m_read", {31'd0, m_read}, 32'd0);
    check_val("rst_s_readdata", s_readdata, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // Disabled: toggling input must never trigger a scan.
    no_scan_chk = 1'b1;
    for (int i = 0; i < 40; i++) begin in_port = 16'($urandom); step(); end
    bus_read(2'd0, rd);
    check_val("state_disabled", rd, 32'd0);
    no_scan_chk = 1'b0;
    in_port = 16'd0;

    // Period 9 -> one strobe every 10 clk.
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, {16'd9, 15'd0, 1'b1});
    int_chk = 1'b1; exp_int = 10; pulses = 0;
    run(45);
    int_chk = 1'b0;
    check_val("pulse_count", {31'd0, pulses >= 4}, 32'd1);

    // Glitch lasting one scan is rejected.
    wait_mread(20);
    in_port = 16'h0001;
    step();
    in_port = 16'h0000;
    run(50);
    bus_read(2'd0, rd); check_val("glitch_state", rd, 32'd0);
    bus_read(2'd1, rd); check_val("glitch_edge", rd, 32'd0);

    // Stable 0x00A5 accepted after four scans.
    in_port = 16'h00A5;
    run(60);
    bus_read(2'd0, rd); check_val("a5_state", rd, 32'h0000_00A5);
    bus_read(2'd1, rd); check_val("a5_edge", rd, 32'h0000_00A5);
    check_val("a5_irq", {31'd0, irq}, 32'd1);

    in_port = 16'h0005;
    run(60);
    bus_read(2'd1, rd); check_val("fall_edge", rd, 32'h00A0_00A5);
    bus_write(2'd1, 32'h00A0_00A5);
    bus_read(2'd1, rd); check_val("w1c_edge", rd, 32'd0);
    check_val("w1c_irq", {31'd0, irq}, 32'd0);

    // Clear of rise bit0 lands on the same clk as its new rise.
    bus_write(2'd3, {16'd2, 15'd0, 1'b1});
    in_port = 16'h0004;
    run(30);
    in_port = 16'h0005;
    for (int i = 0; i < 12; i++) begin
      wait_mread(10);
      step();
      s_write = 1'b1; s_address = 2'd1; s_writedata = 32'h0000_0001;
      step();
      s_write = 1'b0; s_address = 2'd0; s_writedata = 32'd0;
      if (edge_m[0]) break;
    end
    bus_read(2'd1, rd); check_val("set_wins", rd, 32'h0001_0001);

    // Randomized traffic.
    bus_write(2'd3, {16'd1, 15'd0, 1'b1});
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0)
        in_port = ($urandom_range(0, 4) == 4) ? 16'($urandom) : pats[$urandom_range(0, 3)];
      case ($urandom_range(0, 11))
        0: begin s_read = 1'b1; s_address = 2'($urandom); end
        1: begin s_write = 1'b1; s_address = 2'd1; s_writedata = $urandom; end
        2: begin s_write = 1'b1; s_address = 2'd2; s_writedata = $urandom; end
        3: begin s_write = 1'b1; s_address = 2'd3;
                 s_writedata = {16'($urandom_range(0, 4)), 15'd0, 1'($urandom_range(0, 5) != 0)}; end
        4: begin s_write = 1'b1; s_address = 2'd0; s_writedata = $urandom; end
        default: ;
      endcase
      step();
      s_read = 1'b0; s_write = 1'b0; s_address = 2'd0; s_writedata = 32'd0;
    end

    // Reset asserted while a read request is on the bus.
    bus_write(2'd3, {16'd1, 15'd0, 1'b1});
    bus_write(2'd2, 32'hFFFF_FFFF);
    wait_mread(20);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_m_read", {31'd0, m_read}, 32'd0);
    check_val("mid_rst_s_readdata", s_readdata, 32'd0);
    check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    bus_read(2'd0, rd); check_val("post_rst_state", rd, 32'd0);
    bus_read(2'd3, rd); check_val("post_rst_ctrl", rd, 32'd0);
    bus_write(2'd3, {16'd1, 15'd0, 1'b1});
    in_port = 16'h0003;
    run(40);
    bus_read(2'd1, rd); check_val("post_rst_rise", rd, 32'h0000_0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
